// File: rtl/audio_pkg.sv
// Shared types and default sizes for the audio record/playback memory sequencer.
package audio_pkg;

  localparam int AUDIO_DATA_W = 8;
  localparam int AUDIO_ADDR_W = 17;
  localparam int AUDIO_DEPTH  = 120000;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REC     = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_CAP  = 3'd3,
    S_HOLD    = 3'd4,
    S_DONE    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/seq_counter.sv
// Sample counter with synchronous clear, increment enable and a terminal flag
// that compares the current count against a caller-chosen limit.
module seq_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             term_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == limit_i);

endmodule

// File: rtl/audio_mem_sequencer.sv
// Walks RAM addresses for the record/playback controller: records deserializer
// samples into RAM, or plays them back to the serializer, then raises tme.
module audio_mem_sequencer
  import audio_pkg::*;
#(
  parameter  int DATA_W = AUDIO_DATA_W,
  parameter  int ADDR_W = AUDIO_ADDR_W,
  parameter  int DEPTH  = AUDIO_DEPTH,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN_time,
  input  logic              reset_time,
  input  logic              wea,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              tme,
  output logic [CNT_W-1:0]  rec_len,
  output seq_state_t        dbg_state
);

  // Handshake: a sample moves to the serializer on any cycle where m_valid and
  // m_ready are both high; while m_valid waits, m_data does not change.

  seq_state_t        state_q, state_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              ram_we_q, ram_we_d;
  logic              tme_q, tme_d;
  logic [CNT_W-1:0]  rec_len_q, rec_len_d;

  logic [CNT_W-1:0]  cnt, cnt_limit;
  logic              cnt_inc, cnt_term, cnt_clr;

  assign cnt_clr = rst | reset_time | (state_d == S_IDLE);

  seq_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .limit_i (cnt_limit),
    .cnt_o   (cnt),
    .term_o  (cnt_term)
  );

  always_comb begin
    state_d    = state_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = 1'b0;
    rec_len_d  = rec_len_q;
    cnt_inc    = 1'b0;
    cnt_limit  = rec_len_q;

    case (state_q)
      S_IDLE: begin
        if (EN_time) begin
          if (wea) begin
            state_d = S_REC;
          end else if (rec_len_q != '0) begin
            state_d    = S_RD_ADDR;
            ram_addr_d = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_REC: begin
        // Terminal one short of DEPTH flags the write that fills the buffer.
        cnt_limit = CNT_W'(DEPTH - 1);
        if (!EN_time) begin
          rec_len_d = cnt;
          state_d   = S_IDLE;
        end else if (s_valid) begin
          ram_we_d   = 1'b1;
          ram_addr_d = ADDR_W'(cnt);
          ram_din_d  = s_data;
          cnt_inc    = 1'b1;
          if (cnt_term) begin
            rec_len_d = CNT_W'(DEPTH);
            state_d   = S_DONE;
          end
        end
      end
      S_RD_ADDR: begin
        if (!EN_time) begin
          m_valid_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          state_d = S_RD_CAP;
        end
      end
      S_RD_CAP: begin
        if (!EN_time) begin
          m_valid_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          m_data_d  = ram_dout;
          m_valid_d = 1'b1;
          cnt_inc   = 1'b1;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!EN_time) begin
          m_valid_d = 1'b0;
          state_d   = S_IDLE;
        end else if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          if (cnt_term) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_RD_ADDR;
            ram_addr_d = ADDR_W'(cnt);
          end
        end
      end
      S_DONE: begin
        if (!EN_time) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    tme_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst || reset_time) begin
      state_q    <= S_IDLE;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
      tme_q      <= 1'b0;
      rec_len_q  <= '0;
    end else begin
      state_q    <= state_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_we_q   <= ram_we_d;
      tme_q      <= tme_d;
      rec_len_q  <= rec_len_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_we    = ram_we_q;
  assign tme       = tme_q;
  assign rec_len   = rec_len_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_audio_mem_sequencer.sv
// Bench for audio_mem_sequencer: random record/playback sessions checked
// against a sample-list model of what the RAM and the serializer should see.
module tb_audio_mem_sequencer;
  import audio_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 17;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WR_W   = ADDR_W + DATA_W;
  localparam int MEM_AW = $clog2(DEPTH);
  localparam int BUDGET = 2000;

  logic              clk = 1'b0;
  logic              rst, EN_time, reset_time, wea, s_valid, m_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid, ram_we, tme;
  logic [DATA_W-1:0] m_data, ram_din, ram_dout;
  logic [ADDR_W-1:0] ram_addr;
  logic [CNT_W-1:0]  rec_len;
  seq_state_t        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int n_accept;

  logic [WR_W-1:0]   exp_wr_q[$];
  logic [DATA_W-1:0] exp_rd_q[$];
  logic [DATA_W-1:0] rec_model[$];
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  audio_mem_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .EN_time    (EN_time),
    .reset_time (reset_time),
    .wea        (wea),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .m_ready    (m_ready),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout),
    .tme        (tme),
    .rec_len    (rec_len),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[MEM_AW-1:0]] <= ram_din;
    ram_dout <= mem[ram_addr[MEM_AW-1:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  logic              held_v = 1'b0;
  logic [DATA_W-1:0] held_d;

  always @(negedge clk) begin
    logic [WR_W-1:0] w;
    if (ram_we === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        check("ram_we_unexpected", 32'(ram_addr), 32'hFFFF_FFFF);
      end else begin
        w = exp_wr_q.pop_front();
        check("wr_addr", 32'(ram_addr), 32'(w[WR_W-1:DATA_W]));
        check("wr_data", 32'(ram_din), 32'(w[DATA_W-1:0]));
      end
    end
    if (m_valid === 1'b1) begin
      if (held_v) check("stall_stable", 32'(m_data), 32'(held_d));
      if (exp_rd_q.size() == 0) begin
        check("m_valid_unexpected", 32'(m_data), 32'hFFFF_FFFF);
      end else if (m_ready === 1'b1) begin
        check("m_data", 32'(m_data), 32'(exp_rd_q.pop_front()));
        n_accept++;
      end
    end
    held_v = (m_valid === 1'b1) && (m_ready !== 1'b1);
    held_d = m_data;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; EN_time = 1'b0; reset_time = 1'b0; wea = 1'b0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    tick();
    tick();
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_ram_din", 32'(ram_din), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_tme", 32'(tme), 0);
    check("rst_rec_len", 32'(rec_len), 0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b0;
    rec_model.delete();
    tick();
  endtask

  // Offers n samples (fixed ramp from base, or random if base < 0), with random
  // idle gaps up to max_gap, then releases EN_time.
  task automatic record(input int n, input int max_gap, input int base);
    int mcnt;
    mcnt = 0;
    rec_model.delete();
    EN_time = 1'b1; wea = 1'b1;
    tick();
    wea = 1'($urandom_range(1, 0));
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        tick();
        check("tme_rec_gap", 32'(tme), 32'(mcnt == DEPTH));
      end
      s_valid = 1'b1;
      s_data  = (base < 0) ? DATA_W'($urandom) : DATA_W'(base + i);
      if (mcnt < DEPTH) begin
        exp_wr_q.push_back({ADDR_W'(mcnt), s_data});
        rec_model.push_back(s_data);
      end
      tick();
      s_valid = 1'b0;
      if (mcnt < DEPTH) mcnt++;
      check("tme_rec", 32'(tme), 32'(mcnt == DEPTH));
    end
    if (mcnt == DEPTH) begin
      tick();
      check("full_tme", 32'(tme), 1);
      check("full_rec_len", 32'(rec_len), 32'(DEPTH));
    end
    EN_time = 1'b0;
    tick();
    check("rec_end_tme", 32'(tme), 0);
    check("rec_len", 32'(rec_len), 32'(mcnt));
    check("rec_end_state", 32'(dbg_state), 32'(S_IDLE));
    check("wr_all_seen", 32'(exp_wr_q.size()), 0);
    exp_wr_q.delete();
  endtask

  // Plays back the recording; each sample is stalled a random number of
  // cycles in [smin, smax] before m_ready is raised.
  task automatic play(input int smin, input int smax);
    int cycles, st, cur;
    foreach (rec_model[i]) exp_rd_q.push_back(rec_model[i]);
    n_accept = 0; st = 0; cycles = 0;
    cur = $urandom_range(smax, smin);
    EN_time = 1'b1; wea = 1'b0;
    tick();
    wea = 1'($urandom_range(1, 0));
    while (tme !== 1'b1 && cycles < BUDGET) begin
      if (m_valid === 1'b1) begin
        if (st >= cur) begin
          m_ready = 1'b1; st = 0; cur = $urandom_range(smax, smin);
        end else begin
          m_ready = 1'b0; st++;
        end
      end else begin
        m_ready = 1'($urandom_range(1, 0));
      end
      tick();
      cycles++;
    end
    check("play_timeout", 32'(cycles < BUDGET), 1);
    if (rec_model.size() == 0) check("empty_tme_latency", 32'(cycles <= 1), 1);
    check("play_accepts", 32'(n_accept), 32'(rec_model.size()));
    check("play_left", 32'(exp_rd_q.size()), 0);
    repeat (2) begin
      m_ready = 1'($urandom_range(1, 0));
      tick();
      check("done_hold_tme", 32'(tme), 1);
    end
    EN_time = 1'b0; m_ready = 1'b0;
    tick();
    check("play_end_tme", 32'(tme), 0);
    check("play_end_state", 32'(dbg_state), 32'(S_IDLE));
    exp_rd_q.delete();
  endtask

  // Starts playback and pulses reset_time while the third sample is presented.
  task automatic play_reset_mid();
    int cycles;
    foreach (rec_model[i]) exp_rd_q.push_back(rec_model[i]);
    n_accept = 0; cycles = 0;
    EN_time = 1'b1; wea = 1'b0; m_ready = 1'b1;
    tick();
    while (!(n_accept == 2 && m_valid === 1'b1) && cycles < BUDGET) begin
      tick();
      cycles++;
    end
    check("mid_timeout", 32'(cycles < BUDGET), 1);
    m_ready = 1'b0;
    reset_time = 1'b1;
    tick();
    reset_time = 1'b0;
    EN_time = 1'b0;
    exp_rd_q.delete();
    rec_model.delete();
    check("rt_state", 32'(dbg_state), 32'(S_IDLE));
    check("rt_m_valid", 32'(m_valid), 0);
    check("rt_rec_len", 32'(rec_len), 0);
    check("rt_tme", 32'(tme), 0);
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    do_reset();
    play(0, 0);                 // nothing recorded: tme right away
    record(5, 0, 8'h11);        // 0x11..0x15, then abort
    play(0, 0);
    play(10, 10);
    record(11, 0, -1);          // continuous strobes past DEPTH
    play(0, 3);
    for (int r = 0; r < 4; r++) begin
      record($urandom_range(10, 1), 2, -1);
      play(0, 4);
    end
    record(5, 1, -1);
    play_reset_mid();
    play(0, 2);                 // rec_len cleared: immediate tme
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
